// File: rtl/sr_rx_ctrl.sv
// Receive sequencer for an LSB-first serial-to-parallel shift register.
// It synchronises the line, times mid-bit sampling, checks the stop bit and tracks the valid and overrun handshake.
module sr_rx_ctrl #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic data_read,
    output logic sync_bit,
    output logic shift_enable,
    output logic load_buffer,
    output logic rx_valid,
    output logic framing_error,
    output logic overrun_error,
    output logic busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int DW   = $clog2(NUM_BITS + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [DW-1:0] DAT_LAST = DW'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_LOAD
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_bits;
    logic          r_rx_valid;
    logic          r_framing;
    logic          r_overrun;

    logic          w_bit_end;
    logic          w_load;

    assign w_bit_end = (r_cnt == BIT_LAST);
    assign w_load    = (r_state == S_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_rx_valid <= 1'b0;
            r_framing  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            case (r_state)
                S_IDLE: begin
                    if (!r_sync2 && r_prev) begin
                        r_state   <= S_START;
                        r_cnt     <= '0;
                        r_framing <= 1'b0;
                    end
                end
                S_START: begin
                    // A start bit that is high again by mid-bit is treated as a glitch.
                    if (r_cnt == HALF_M1) begin
                        r_cnt  <= '0;
                        r_bits <= '0;
                        r_state <= r_sync2 ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt  <= '0;
                        r_bits <= r_bits + 1'b1;
                        if (r_bits == DAT_LAST) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_framing <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A load wins over a simultaneous read, so the fresh word stays pending.
            if (w_load) begin
                r_rx_valid <= 1'b1;
            end else if (data_read) begin
                r_rx_valid <= 1'b0;
            end

            if (w_load && r_rx_valid && !data_read) begin
                r_overrun <= 1'b1;
            end else if (data_read && !w_load) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign sync_bit      = r_sync2;
    assign shift_enable  = (r_state == S_DATA) && w_bit_end;
    assign load_buffer   = w_load;
    assign rx_valid      = r_rx_valid;
    assign framing_error = r_framing;
    assign overrun_error = r_overrun;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_sr_rx_ctrl.sv
// Scoreboarded bench for sr_rx_ctrl: expected shift/load cycles and words are queued when a frame is driven
// and popped by a negedge monitor; the external shift register is modelled here.
module tb_sr_rx_ctrl;

    localparam int NB   = 8;
    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;

    logic clk = 1'b0;
    logic rst;
    logic serial_in;
    logic data_read;
    logic sync_bit;
    logic shift_enable;
    logic load_buffer;
    logic rx_valid;
    logic framing_error;
    logic overrun_error;
    logic busy;

    sr_rx_ctrl #(
        .NUM_BITS    (NB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .sync_bit     (sync_bit),
        .shift_enable (shift_enable),
        .load_buffer  (load_buffer),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int         exp_shift[$];
    int         exp_load_cyc[$];
    logic [7:0] exp_load_data[$];
    bit         abort_tx = 1'b0;

    wire [6:0] outs = {sync_bit, shift_enable, load_buffer, rx_valid, framing_error, overrun_error, busy};

    // Behavioural LSB-first shift register fed by the DUT.
    logic [NB-1:0] sr_model;
    always @(posedge clk or posedge rst) begin
        if (rst) sr_model <= '0;
        else if (shift_enable) sr_model <= {sync_bit, sr_model[NB-1:1]};
    end

    always @(negedge clk) begin
        if (shift_enable) begin
            checks++;
            if (exp_shift.size() == 0) begin
                errors++;
                $display("FAIL shift_unexpected at cycle %0d", cyc);
            end else begin
                if (exp_shift[0] !== cyc) begin
                    errors++;
                    $display("FAIL shift_time got cycle %0d expected %0d", cyc, exp_shift[0]);
                end
                exp_shift.delete(0);
            end
        end else if (exp_shift.size() > 0 && exp_shift[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL shift_missed got none expected cycle %0d", exp_shift[0]);
            exp_shift.delete(0);
        end

        if (load_buffer) begin
            checks++;
            if (exp_load_cyc.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected at cycle %0d word %h", cyc, sr_model);
            end else begin
                if (exp_load_cyc[0] !== cyc || sr_model !== exp_load_data[0]) begin
                    errors++;
                    $display("FAIL load got cycle %0d word %h expected cycle %0d word %h",
                             cyc, sr_model, exp_load_cyc[0], exp_load_data[0]);
                end else begin
                    $display("load cycle %0d word %h", cyc, sr_model);
                end
                exp_load_cyc.delete(0);
                exp_load_data.delete(0);
            end
        end else if (exp_load_cyc.size() > 0 && exp_load_cyc[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL load_missed got none expected cycle %0d", exp_load_cyc[0]);
            exp_load_cyc.delete(0);
            exp_load_data.delete(0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // Drives one frame starting in the current cycle; the edge cycle E is two cycles later.
    task automatic send_frame(input logic [7:0] data, input bit stop, input int stop_len);
        int e;
        int len;
        e = cyc + 2;
        for (int k = 1; k <= NB; k++) exp_shift.push_back(e + HALF + k * CPB);
        if (stop) begin
            exp_load_cyc.push_back(e + HALF + (NB + 1) * CPB + 1);
            exp_load_data.push_back(data);
        end
        for (int b = 0; b < NB + 2 && !abort_tx; b++) begin
            len = (b == NB + 1) ? stop_len : CPB;
            if (b == 0) serial_in = 1'b0;
            else if (b == NB + 1) serial_in = stop;
            else serial_in = data[b-1];
            for (int c = 0; c < len && !abort_tx; c++) step();
        end
        serial_in = 1'b1;
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        step();
        data_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (3) step();
        checks++;
        if (outs !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs got %b expected %b", outs, 7'b1000000);
        end
        rst = 1'b0;
        repeat (4) step();
        checks++;
        if (outs !== 7'b1000000) begin
            errors++;
            $display("FAIL idle_outputs got %b expected %b", outs, 7'b1000000);
        end
    endtask

    task automatic test_frame_55();
        int e;
        e = cyc + 2;
        fork
            send_frame(8'h55, 1'b1, CPB);
            begin
                wait_to(e);
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_E got %b expected 0", busy); end
                wait_to(e + 1);
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL busy_at_E1 got %b expected 1", busy); end
                wait_to(e + 96);
                checks++;
                if (rx_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL load_cycle_state got rx_valid %b busy %b expected 0 1", rx_valid, busy);
                end
                wait_to(e + 97);
                checks++;
                if (rx_valid !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL after_load got rx_valid %b busy %b expected 1 0", rx_valid, busy);
                end
            end
        join
        repeat (3) step();
    endtask

    task automatic test_glitch();
        int e;
        e = cyc + 2;
        serial_in = 1'b0;
        repeat (3) step();
        serial_in = 1'b1;
        wait_to(e + 5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start got busy %b expected 1", busy); end
        wait_to(e + 6);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy %b expected 0", busy); end
        wait_to(e + 30);
        checks++;
        if ({rx_valid, framing_error, overrun_error} !== 3'b100) begin
            errors++;
            $display("FAIL glitch_flags got %b expected 100", {rx_valid, framing_error, overrun_error});
        end
    endtask

    task automatic test_framing();
        int e;
        e = cyc + 2;
        fork
            send_frame(8'hA3, 1'b0, CPB);
            begin
                wait_to(e + 95);
                checks++;
                if (framing_error !== 1'b0) begin errors++; $display("FAIL framing_early got %b expected 0", framing_error); end
                wait_to(e + 96);
                checks++;
                if ({framing_error, busy, rx_valid} !== 3'b101) begin
                    errors++;
                    $display("FAIL framing_set got fe/busy/rxv %b expected 101", {framing_error, busy, rx_valid});
                end
            end
        join
        repeat (3) step();
        pulse_read();
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL read_clear got %b expected 0", rx_valid); end
        repeat (3) step();
        e = cyc + 2;
        fork
            send_frame(8'h3C, 1'b1, CPB);
            begin
                wait_to(e);
                checks++;
                if (framing_error !== 1'b1) begin errors++; $display("FAIL framing_hold got %b expected 1", framing_error); end
                wait_to(e + 1);
                checks++;
                if (framing_error !== 1'b0) begin errors++; $display("FAIL framing_clear got %b expected 0", framing_error); end
                wait_to(e + 97);
                checks++;
                if ({rx_valid, overrun_error} !== 2'b10) begin
                    errors++;
                    $display("FAIL frame_3c got rxv/ovr %b expected 10", {rx_valid, overrun_error});
                end
            end
        join
        repeat (3) step();
        pulse_read();
    endtask

    task automatic test_overrun();
        int e;
        send_frame(8'h12, 1'b1, CPB);
        e = cyc + 2;
        fork
            send_frame(8'h34, 1'b1, CPB);
            begin
                wait_to(e + 96);
                checks++;
                if ({rx_valid, overrun_error} !== 2'b10) begin
                    errors++;
                    $display("FAIL overrun_before got rxv/ovr %b expected 10", {rx_valid, overrun_error});
                end
                wait_to(e + 97);
                checks++;
                if ({rx_valid, overrun_error} !== 2'b11) begin
                    errors++;
                    $display("FAIL overrun_set got rxv/ovr %b expected 11", {rx_valid, overrun_error});
                end
            end
        join
        repeat (3) step();
        pulse_read();
        checks++;
        if ({rx_valid, overrun_error} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_clear got rxv/ovr %b expected 00", {rx_valid, overrun_error});
        end
        repeat (3) step();
    endtask

    // Second start edge lands in the first IDLE cycle after LOAD; read coincides with the second LOAD.
    task automatic test_back_to_back();
        int e1;
        int e2;
        e1 = cyc + 2;
        e2 = e1 + 97;
        fork
            begin
                send_frame(8'h5A, 1'b1, HALF + 2);
                send_frame(8'hC3, 1'b1, CPB);
            end
            begin
                wait_to(e2);
                checks++;
                if ({busy, rx_valid} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_idle got busy/rxv %b expected 01", {busy, rx_valid});
                end
                wait_to(e2 + 1);
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start got busy %b expected 1", busy); end
                wait_to(e2 + 96);
                data_read = 1'b1;
                step();
                data_read = 1'b0;
                checks++;
                if ({rx_valid, overrun_error} !== 2'b10) begin
                    errors++;
                    $display("FAIL read_in_load got rxv/ovr %b expected 10", {rx_valid, overrun_error});
                end
            end
        join
        repeat (3) step();
    endtask

    task automatic test_reset_midframe();
        int e;
        e = cyc + 2;
        fork
            send_frame(8'hC5, 1'b1, CPB);
            begin
                wait_to(e + 40);
                rst = 1'b1;
                abort_tx = 1'b1;
                exp_shift.delete();
                exp_load_cyc.delete();
                exp_load_data.delete();
                #1;
                checks++;
                if (outs !== 7'b1000000) begin
                    errors++;
                    $display("FAIL midframe_reset got %b expected %b", outs, 7'b1000000);
                end
            end
        join
        repeat (4) step();
        rst = 1'b0;
        abort_tx = 1'b0;
        repeat (4) step();
        e = cyc + 2;
        fork
            send_frame(8'h0F, 1'b1, CPB);
            begin
                wait_to(e + 97);
                checks++;
                if ({rx_valid, framing_error, overrun_error} !== 3'b100) begin
                    errors++;
                    $display("FAIL after_reset_frame got %b expected 100", {rx_valid, framing_error, overrun_error});
                end
            end
        join
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        serial_in = 1'b1;
        data_read = 1'b0;
        step();
        test_reset();
        test_frame_55();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        repeat (5) step();
        checks++;
        if (exp_shift.size() != 0 || exp_load_cyc.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d shifts %0d loads pending expected 0 0",
                     exp_shift.size(), exp_load_cyc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
